// File: rtl/hazard_pkg.sv
// Shared definitions for the dual-issue hazard scoreboard and its partners.
// Holds the register-index and counter widths, the default producer latencies
// (also used by the forwarding unit bench), the ID-stage FSM state type and a
// helper that picks the scoreboard load value for an issuing instruction.
package hazard_pkg;

   localparam int NREG_DEF     = 8;
   localparam int REG_W        = 3;
   localparam int CNT_W        = 2;
   localparam int LOAD_LAT_DEF = 1;
   localparam int ALU_LAT_DEF  = 0;

   // PAIR: a fresh bundle sits in ID. SECOND: slot 1 of the held bundle is gone.
   typedef enum logic [0:0] {
      PAIR   = 1'b0,
      SECOND = 1'b1
   } hz_state_e;

   // Number of cycles a freshly written register stays unforwardable.
   function automatic logic [CNT_W-1:0] issue_lat(
      input logic             memread,
      input logic [CNT_W-1:0] load_lat,
      input logic [CNT_W-1:0] alu_lat
   );
      return memread ? load_lat : alu_lat;
   endfunction

endpackage

// File: rtl/hazard_src_check.sv
// Source-operand hazard check for one issue slot.
// Ports:
//   rsa_i / rsb_i   : the slot's two source register indices
//   usea_i / useb_i : the matching source field is really read
//   cnt_i           : scoreboard counters, one CNT_W field per register
//   blocked_o       : some used, nonzero source still has a nonzero counter
// Register 0 never hazards regardless of its counter contents.
module hazard_src_check
   import hazard_pkg::*;
#(
   parameter int NREG = NREG_DEF
) (
   input  logic [REG_W-1:0]            rsa_i,
   input  logic [REG_W-1:0]            rsb_i,
   input  logic                        usea_i,
   input  logic                        useb_i,
   input  logic [NREG-1:0][CNT_W-1:0]  cnt_i,
   output logic                        blocked_o
);

   logic a_busy_s;
   logic b_busy_s;

   assign a_busy_s  = usea_i && (rsa_i != {REG_W{1'b0}}) && (cnt_i[rsa_i] != {CNT_W{1'b0}});
   assign b_busy_s  = useb_i && (rsb_i != {REG_W{1'b0}}) && (cnt_i[rsb_i] != {CNT_W{1'b0}});
   assign blocked_o = a_busy_s || b_busy_s;

endmodule

// File: rtl/dual_issue_hazard_scoreboard.sv
// Dual-issue hazard scoreboard (producer side of forwarding).
// Tracks, per architectural register, how many more cycles its pending result
// cannot be forwarded, and decides in ID whether the bundle issues whole,
// issues split (slot 1 now, slot 2 next) or stalls.
// Ports:
//   clk, rst_n                 : clock (rising edge), async active-low reset
//   id_valid{1,2}_i            : slot holds a valid instruction
//   id_rd{1,2}_i               : destination register
//   id_regwrite{1,2}_i         : slot writes its rd
//   id_memread{1,2}_i          : slot is a load
//   id_rs{a,b}{1,2}_i          : source registers
//   id_use{a,b}{1,2}_i         : source field actually read
//   id_setflag1_i              : slot 1 writes the N flag
//   id_useflag2_i              : slot 2 reads the N flag
//   ex_flush_i                 : branch redirect, kill ID bundle
//   stall_id_o                 : hold PC, IF/ID and ID inputs
//   bubble_ex{1,2}_o           : insert NOP into EX slot register
//   pending_mask_o             : bit r set while cnt[r] != 0 (debug)
// Decisions are combinational from state, counters and ID inputs; while rst_n
// is low the outputs are forced to their idle values without a clock edge.
module dual_issue_hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREG     = NREG_DEF,
   parameter int LOAD_LAT = LOAD_LAT_DEF,
   parameter int ALU_LAT  = ALU_LAT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid1_i,
   input  logic             id_valid2_i,
   input  logic [REG_W-1:0] id_rd1_i,
   input  logic [REG_W-1:0] id_rd2_i,
   input  logic             id_regwrite1_i,
   input  logic             id_regwrite2_i,
   input  logic             id_memread1_i,
   input  logic             id_memread2_i,
   input  logic [REG_W-1:0] id_rsa1_i,
   input  logic [REG_W-1:0] id_rsb1_i,
   input  logic [REG_W-1:0] id_rsa2_i,
   input  logic [REG_W-1:0] id_rsb2_i,
   input  logic             id_usea1_i,
   input  logic             id_useb1_i,
   input  logic             id_usea2_i,
   input  logic             id_useb2_i,
   input  logic             id_setflag1_i,
   input  logic             id_useflag2_i,
   input  logic             ex_flush_i,
   output logic             stall_id_o,
   output logic             bubble_ex1_o,
   output logic             bubble_ex2_o,
   output logic [NREG-1:0]  pending_mask_o
);

   localparam logic [CNT_W-1:0] LOAD_LAT_C = CNT_W'(LOAD_LAT);
   localparam logic [CNT_W-1:0] ALU_LAT_C  = CNT_W'(ALU_LAT);

   hz_state_e                   state_q;
   hz_state_e                   state_d;
   logic [NREG-1:0][CNT_W-1:0]  cnt_q;
   logic [NREG-1:0][CNT_W-1:0]  cnt_d;

   logic src1_blk_s;
   logic src2_blk_s;
   logic blk1_s;
   logic blk2_s;
   logic dep_s;
   logic take1_s;
   logic take2_s;
   logic load1_s;
   logic load2_s;
   logic stall_s;
   logic bub1_s;
   logic bub2_s;
   logic [CNT_W-1:0] lat1_s;
   logic [CNT_W-1:0] lat2_s;

   hazard_src_check #(.NREG(NREG)) u_src_chk1 (
      .rsa_i     (id_rsa1_i),
      .rsb_i     (id_rsb1_i),
      .usea_i    (id_usea1_i),
      .useb_i    (id_useb1_i),
      .cnt_i     (cnt_q),
      .blocked_o (src1_blk_s)
   );

   hazard_src_check #(.NREG(NREG)) u_src_chk2 (
      .rsa_i     (id_rsa2_i),
      .rsb_i     (id_rsb2_i),
      .usea_i    (id_usea2_i),
      .useb_i    (id_useb2_i),
      .cnt_i     (cnt_q),
      .blocked_o (src2_blk_s)
   );

   // An invalid slot is an issued bubble, so it can never block.
   assign blk1_s = id_valid1_i && src1_blk_s;
   assign blk2_s = id_valid2_i && src2_blk_s;

   // Slot 2 consumes something slot 1 of the same bundle produces.
   assign dep_s = id_valid1_i && id_valid2_i &&
                  ((id_regwrite1_i && (id_rd1_i != {REG_W{1'b0}}) &&
                    ((id_usea2_i && (id_rsa2_i == id_rd1_i)) ||
                     (id_useb2_i && (id_rsb2_i == id_rd1_i)))) ||
                   (id_setflag1_i && id_useflag2_i));

   // Issue decision and next state; flush overrides every other outcome.
   always_comb begin
      state_d = state_q;
      stall_s = 1'b0;
      bub1_s  = 1'b0;
      bub2_s  = 1'b0;
      take1_s = 1'b0;
      take2_s = 1'b0;
      if (ex_flush_i) begin
         state_d = PAIR;
         bub1_s  = 1'b1;
         bub2_s  = 1'b1;
      end else begin
         case (state_q)
            PAIR: begin
               if (blk1_s) begin
                  stall_s = 1'b1;
                  bub1_s  = 1'b1;
                  bub2_s  = 1'b1;
               end else if (dep_s || blk2_s) begin
                  take1_s = 1'b1;
                  stall_s = 1'b1;
                  bub2_s  = 1'b1;
                  state_d = SECOND;
               end else begin
                  take1_s = 1'b1;
                  take2_s = 1'b1;
               end
            end
            SECOND: begin
               // Slot 1 of this bundle already left for EX on the previous edge.
               bub1_s = 1'b1;
               if (blk2_s) begin
                  stall_s = 1'b1;
                  bub2_s  = 1'b1;
               end else begin
                  take2_s = 1'b1;
                  state_d = PAIR;
               end
            end
            default: begin
               state_d = PAIR;
               bub1_s  = 1'b1;
               bub2_s  = 1'b1;
            end
         endcase
      end
   end

   assign load1_s = take1_s && id_valid1_i && id_regwrite1_i && (id_rd1_i != {REG_W{1'b0}});
   assign load2_s = take2_s && id_valid2_i && id_regwrite2_i && (id_rd2_i != {REG_W{1'b0}});
   assign lat1_s  = issue_lat(id_memread1_i, LOAD_LAT_C, ALU_LAT_C);
   assign lat2_s  = issue_lat(id_memread2_i, LOAD_LAT_C, ALU_LAT_C);

   // Counter next state: slot 2 beats slot 1 on WAW, otherwise saturating decrement.
   always_comb begin
      cnt_d = cnt_q;
      for (int r = 0; r < NREG; r++) begin
         if (r == 0) begin
            cnt_d[r] = {CNT_W{1'b0}};
         end else if (load2_s && (id_rd2_i == REG_W'(r))) begin
            cnt_d[r] = lat2_s;
         end else if (load1_s && (id_rd1_i == REG_W'(r))) begin
            cnt_d[r] = lat1_s;
         end else if (cnt_q[r] != {CNT_W{1'b0}}) begin
            cnt_d[r] = cnt_q[r] - CNT_W'(1);
         end else begin
            cnt_d[r] = {CNT_W{1'b0}};
         end
      end
   end

   // State and scoreboard registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PAIR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Debug view of which registers are still unforwardable.
   always_comb begin
      pending_mask_o = '0;
      for (int r = 0; r < NREG; r++) begin
         pending_mask_o[r] = |cnt_q[r];
      end
   end

   // Reset forces idle outputs immediately, independent of the clock.
   assign stall_id_o   = rst_n & stall_s;
   assign bubble_ex1_o = ~rst_n | bub1_s;
   assign bubble_ex2_o = ~rst_n | bub2_s;

endmodule

// File: tb/tb_dual_issue_hazard_scoreboard.sv
// Self-checking bench for dual_issue_hazard_scoreboard: directed scenarios
// followed by randomized bundles, all compared against a reference model that
// tracks, per register, the cycle at which its result becomes forwardable.
module tb_dual_issue_hazard_scoreboard;

   localparam int LOAD_LAT = 1;
   localparam int ALU_LAT  = 0;

   typedef struct packed {
      bit       v1, v2, rw1, rw2, mr1, mr2;
      bit [2:0] rd1, rd2, ra1, rb1, ra2, rb2;
      bit       ua1, ub1, ua2, ub2, sf1, uf2, flush;
   } bundle_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid1_i, id_valid2_i, id_regwrite1_i, id_regwrite2_i;
   logic       id_memread1_i, id_memread2_i;
   logic [2:0] id_rd1_i, id_rd2_i, id_rsa1_i, id_rsb1_i, id_rsa2_i, id_rsb2_i;
   logic       id_usea1_i, id_useb1_i, id_usea2_i, id_useb2_i;
   logic       id_setflag1_i, id_useflag2_i, ex_flush_i;
   logic       stall_id_o, bubble_ex1_o, bubble_ex2_o;
   logic [7:0] pending_mask_o;

   always #5 clk = ~clk;

   dual_issue_hazard_scoreboard #(.NREG(8), .LOAD_LAT(LOAD_LAT), .ALU_LAT(ALU_LAT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_valid1_i    (id_valid1_i),
      .id_valid2_i    (id_valid2_i),
      .id_rd1_i       (id_rd1_i),
      .id_rd2_i       (id_rd2_i),
      .id_regwrite1_i (id_regwrite1_i),
      .id_regwrite2_i (id_regwrite2_i),
      .id_memread1_i  (id_memread1_i),
      .id_memread2_i  (id_memread2_i),
      .id_rsa1_i      (id_rsa1_i),
      .id_rsb1_i      (id_rsb1_i),
      .id_rsa2_i      (id_rsa2_i),
      .id_rsb2_i      (id_rsb2_i),
      .id_usea1_i     (id_usea1_i),
      .id_useb1_i     (id_useb1_i),
      .id_usea2_i     (id_usea2_i),
      .id_useb2_i     (id_useb2_i),
      .id_setflag1_i  (id_setflag1_i),
      .id_useflag2_i  (id_useflag2_i),
      .ex_flush_i     (ex_flush_i),
      .stall_id_o     (stall_id_o),
      .bubble_ex1_o   (bubble_ex1_o),
      .bubble_ex2_o   (bubble_ex2_o),
      .pending_mask_o (pending_mask_o)
   );

   // Reference model: ready_at[r] is the first cycle r's value can be forwarded.
   int  ready_at [8];
   int  cyc;
   bit  held;        // slot 1 of the bundle in ID has already gone to EX
   bit  last_stall;
   int  n_cmp;
   int  n_err;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit busy(input bit [2:0] r);
      return (r != 3'd0) && (cyc < ready_at[r]);
   endfunction

   function automatic int lat_of(input bit mr);
      return mr ? LOAD_LAT : ALU_LAT;
   endfunction

   task automatic apply(input bundle_t b);
      id_valid1_i = b.v1;   id_valid2_i = b.v2;
      id_regwrite1_i = b.rw1; id_regwrite2_i = b.rw2;
      id_memread1_i = b.mr1; id_memread2_i = b.mr2;
      id_rd1_i = b.rd1; id_rd2_i = b.rd2;
      id_rsa1_i = b.ra1; id_rsb1_i = b.rb1; id_rsa2_i = b.ra2; id_rsb2_i = b.rb2;
      id_usea1_i = b.ua1; id_useb1_i = b.ub1; id_usea2_i = b.ua2; id_useb2_i = b.ub2;
      id_setflag1_i = b.sf1; id_useflag2_i = b.uf2; ex_flush_i = b.flush;
   endtask

   // One ID cycle: apply, predict, compare, then commit the model on the edge.
   task automatic step(input bundle_t b);
      bit blk1, blk2, dep, st, e1, e2, w1, w2, nheld;
      bit [7:0] mask;
      apply(b);
      #1;
      blk1 = b.v1 && ((b.ua1 && busy(b.ra1)) || (b.ub1 && busy(b.rb1)));
      blk2 = b.v2 && ((b.ua2 && busy(b.ra2)) || (b.ub2 && busy(b.rb2)));
      dep  = b.v1 && b.v2 &&
             ((b.rw1 && b.rd1 != 3'd0 && ((b.ua2 && b.ra2 == b.rd1) || (b.ub2 && b.rb2 == b.rd1))) ||
              (b.sf1 && b.uf2));
      w1 = 1'b0; w2 = 1'b0; nheld = held;
      if (b.flush) begin
         st = 1'b0; e1 = 1'b1; e2 = 1'b1; nheld = 1'b0;
      end else if (held) begin
         e1 = 1'b1;
         if (blk2) begin st = 1'b1; e2 = 1'b1; end
         else begin st = 1'b0; e2 = 1'b0; w2 = 1'b1; nheld = 1'b0; end
      end else if (blk1) begin
         st = 1'b1; e1 = 1'b1; e2 = 1'b1;
      end else if (dep || blk2) begin
         st = 1'b1; e1 = 1'b0; e2 = 1'b1; w1 = 1'b1; nheld = 1'b1;
      end else begin
         st = 1'b0; e1 = 1'b0; e2 = 1'b0; w1 = 1'b1; w2 = 1'b1;
      end
      for (int r = 0; r < 8; r++) mask[r] = busy(3'(r));
      check_val("stall_id", 32'(stall_id_o), 32'(st));
      check_val("bubble_ex1", 32'(bubble_ex1_o), 32'(e1));
      check_val("bubble_ex2", 32'(bubble_ex2_o), 32'(e2));
      check_val("pending_mask", 32'(pending_mask_o), 32'(mask));
      @(posedge clk);
      if (w1 && b.v1 && b.rw1 && b.rd1 != 3'd0) ready_at[b.rd1] = cyc + lat_of(b.mr1) + 1;
      if (w2 && b.v2 && b.rw2 && b.rd2 != 3'd0) ready_at[b.rd2] = cyc + lat_of(b.mr2) + 1;
      held = nheld;
      last_stall = st;
      cyc++;
      @(negedge clk);
   endtask

   task automatic model_reset();
      for (int r = 0; r < 8; r++) ready_at[r] = 0;
      held = 1'b0;
      last_stall = 1'b0;
   endtask

   function automatic bundle_t rand_bundle();
      bundle_t b;
      b = '0;
      b.v1 = ($urandom_range(0, 7) != 0);  b.v2 = ($urandom_range(0, 7) != 0);
      b.rw1 = $urandom_range(0, 1) == 1;   b.rw2 = $urandom_range(0, 1) == 1;
      b.mr1 = $urandom_range(0, 2) == 0;   b.mr2 = $urandom_range(0, 2) == 0;
      b.rd1 = 3'($urandom_range(0, 7));    b.rd2 = 3'($urandom_range(0, 7));
      b.ra1 = 3'($urandom_range(0, 7));    b.rb1 = 3'($urandom_range(0, 7));
      b.ra2 = 3'($urandom_range(0, 7));    b.rb2 = 3'($urandom_range(0, 7));
      b.ua1 = $urandom_range(0, 1) == 1;   b.ub1 = $urandom_range(0, 1) == 1;
      b.ua2 = $urandom_range(0, 1) == 1;   b.ub2 = $urandom_range(0, 1) == 1;
      b.sf1 = $urandom_range(0, 3) == 0;   b.uf2 = $urandom_range(0, 3) == 0;
      b.flush = $urandom_range(0, 11) == 0;
      return b;
   endfunction

   bundle_t b;

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0;
      model_reset();
      rst_n = 1'b0;
      b = rand_bundle();
      b.flush = 1'b0;
      apply(b);
      #2;
      check_val("rst_stall", 32'(stall_id_o), 32'd0);
      check_val("rst_bub1", 32'(bubble_ex1_o), 32'd1);
      check_val("rst_bub2", 32'(bubble_ex2_o), 32'd1);
      check_val("rst_mask", 32'(pending_mask_o), 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Independent bundle: add r1; add r2.
      b = '0; b.v1 = 1; b.v2 = 1; b.rw1 = 1; b.rw2 = 1; b.rd1 = 3'd1; b.rd2 = 3'd2;
      b.ua1 = 1; b.ra1 = 3'd6; b.ua2 = 1; b.ra2 = 3'd7;
      step(b);

      // Load r3 then load-use in slot 1: one stall cycle, then issue.
      b = '0; b.v1 = 1; b.rw1 = 1; b.mr1 = 1; b.rd1 = 3'd3;
      step(b);
      b = '0; b.v1 = 1; b.v2 = 1; b.ua1 = 1; b.ra1 = 3'd3; b.rw1 = 1; b.rd1 = 3'd4;
      b.rw2 = 1; b.rd2 = 3'd5;
      step(b);
      step(b);

      // Slot 2 reads r4 written by slot 1: split.
      b = '0; b.v1 = 1; b.v2 = 1; b.rw1 = 1; b.rd1 = 3'd4; b.ub2 = 1; b.rb2 = 3'd4;
      step(b);
      step(b);

      // Flag dependency splits; rd1 = 0 feeding r0 reader does not.
      b = '0; b.v1 = 1; b.v2 = 1; b.sf1 = 1; b.uf2 = 1;
      step(b);
      step(b);
      b = '0; b.v1 = 1; b.v2 = 1; b.rw1 = 1; b.rd1 = 3'd0; b.ua2 = 1; b.ra2 = 3'd0;
      step(b);

      // Flush while in SECOND with a pending load.
      b = '0; b.v1 = 1; b.v2 = 1; b.rw1 = 1; b.mr1 = 1; b.rd1 = 3'd6; b.ua2 = 1; b.ra2 = 3'd6;
      step(b);
      b.flush = 1;
      step(b);
      b = '0;
      step(b);
      step(b);

      // Both slots load r5 (WAW): bit 5 pending for one cycle.
      b = '0; b.v1 = 1; b.v2 = 1; b.rw1 = 1; b.rw2 = 1; b.mr1 = 1; b.mr2 = 1;
      b.rd1 = 3'd5; b.rd2 = 3'd5;
      step(b);
      b = '0;
      step(b);
      step(b);

      // Reset asserted in the middle of a load-use stall.
      b = '0; b.v1 = 1; b.rw1 = 1; b.mr1 = 1; b.rd1 = 3'd3;
      step(b);
      b = '0; b.v1 = 1; b.ua1 = 1; b.ra1 = 3'd3;
      apply(b);
      #1;
      check_val("pre_rst_stall", 32'(stall_id_o), 32'd1);
      check_val("pre_rst_mask", 32'(pending_mask_o), 32'h08);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_stall", 32'(stall_id_o), 32'd0);
      check_val("async_rst_bub1", 32'(bubble_ex1_o), 32'd1);
      check_val("async_rst_bub2", 32'(bubble_ex2_o), 32'd1);
      check_val("async_rst_mask", 32'(pending_mask_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(b);

      // Randomized bundles; a stalled bundle is held in ID as a pipeline would.
      for (int i = 0; i < 600; i++) begin
         if (last_stall) begin
            b.flush = ($urandom_range(0, 9) == 0);
         end else begin
            b = rand_bundle();
         end
         step(b);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
